fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage: owns the program counter, drives instruction-memory address, registers fetched instruction into the IF/ID pipeline register.
- Consumes the jmp decision and target from the branch/jump control stage; redirects PC and squashes the wrong-path instruction.
- Supports hazard stall and a terminal halt.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width.
- INSTR_W, 16, instruction word width.
- PC_INC, 2, sequential PC increment in bytes. Legal values are 1 or 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard-unit hold: freeze PC and IF/ID.
- jmp  input  1  taken branch/jump from jump control this cycle.
- jmp_target  input  ADDR_W  redirect address, valid when jmp=1.
- halt  input  1  decoded HALT reached decode; stop fetching.
- imem_addr  output  ADDR_W  instruction memory address, equal to current PC.
- imem_rdata  input  INSTR_W  instruction memory read data, combinational, same cycle as imem_addr.
- if_valid  output  1  IF/ID slot holds a real instruction.
- if_instr  output  INSTR_W  IF/ID instruction.
- if_pc  output  ADDR_W  PC of if_instr.
- halted  output  1  unit is in HALTED state.

Behaviour:
Reset values (asynchronous, rst_n=0):
- pc=RESET_PC, so imem_addr=RESET_PC.
- if_valid=0, if_instr=0, if_pc=0, halted=0.
- state=BOOT.

FSM states: BOOT, RUN, HALTED.
- BOOT: exactly one cycle after rst_n deasserts. if_valid stays 0, pc is not advanced. Next state is RUN unconditionally; halt, jmp and stall are ignored in BOOT.
- RUN: normal fetch. Each non-stalled cycle:
  - IF/ID <= {valid=1, imem_rdata, pc}.
  - pc <= pc+PC_INC.
- HALTED: entered from RUN when halt=1.
  - pc holds; if_valid=0 on the entry edge and thereafter.
  - halted=1 from the cycle after the entry edge.
  - Exit only via reset.

Priority in RUN (highest first):
- halt: go to HALTED, clear if_valid, pc unchanged. jmp and stall ignored.
- jmp:
  - pc <= jmp_target with bit 0 cleared when PC_INC=2.
  - if_valid <= 0 to squash the wrong-path instruction.
  - jmp overrides stall: the instruction in IF/ID is the one being replaced, so no hold is needed.
- stall: pc, if_valid, if_instr and if_pc all hold.
- otherwise: normal advance.

Timing:
- Latency: instruction at address A appears in if_instr one clock after imem_addr=A.
- Jump penalty: exactly one bubble (if_valid=0) for the cycle after the jmp edge. The target instruction is valid the following cycle.

Arithmetic and boundaries:
- PC arithmetic is modulo 2^ADDR_W: pc=16'hFFFE with PC_INC=2 advances to 16'h0000. No overflow flag.
- Consecutive jmp on back-to-back cycles: each redirects; if_valid stays 0 throughout.
- Reset mid-operation: immediate asynchronous return to reset values and BOOT, regardless of state or stall.
- Stall held indefinitely: outputs stable, no drift.

Decomposition:
- types_pkg:
  - fetch_state_t enum {BOOT, RUN, HALTED}.
  - localparam NOP_INSTR, used as the if_instr value on squash. Reset value of if_instr remains 0.
  - Any shared ADDR_W/INSTR_W defaults.
- Sub-module if_id_reg holds the pipeline register:
  - Inputs: load, clear, d_valid, d_instr, d_pc.
  - Outputs: if_valid, if_instr, if_pc.
  - Asynchronous active-low reset.
  - Priority: clear over load over hold.
- The PC register, next-PC mux and FSM stay in fetch_pc_unit.

Test Plan:
- Reset release, no stall, imem returns addr-derived data -> BOOT cycle if_valid=0. Then if_pc=0x0000, 0x0002, 0x0004 on successive cycles with matching if_instr.
- In RUN at pc=0x0010, jmp=1 with jmp_target=0x0041 -> next imem_addr=0x0040. Following cycle if_valid=0; cycle after that if_valid=1, if_pc=0x0040.
- stall=1 for 3 cycles at pc=0x0008 -> imem_addr, if_pc and if_instr unchanged for all 3 cycles. Release: next if_pc=0x0008 then 0x000A.
- stall=1 and jmp=1 together, target 0x0100 -> pc=0x0100 and if_valid=0; jmp wins.
- Force pc to 0xFFFE via jmp_target=0xFFFE, run 2 cycles -> if_pc=0xFFFE then 0x0000.
- halt=1 at pc=0x0020 -> if_valid=0, halted=1 next cycle, pc frozen at 0x0020 despite jmp pulses. rst_n pulse low mid-halt -> immediate reset values, BOOT, resumes at 0x0000.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the fetch FSM encoding, the squash NOP and the default bus widths.
package types_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam int ADDR_W_DEF  = 16;
   localparam int INSTR_W_DEF = 16;

   // Written into if_instr when a slot is squashed; the reset value stays 0.
   localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 16'hF000;

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: one-cycle capture of the fetched instruction and its PC.
// Priority is clear over load over hold, so a held slot (stall) keeps its contents.
module if_id_reg
   import types_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               clear,
   input  logic               d_valid,
   input  logic [INSTR_W-1:0] d_instr,
   input  logic [ADDR_W-1:0]  d_pc,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc
);

   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else if (clear) begin
         valid_q <= 1'b0;
         instr_q <= INSTR_W'(NOP_INSTR);
      end else if (load) begin
         valid_q <= d_valid;
         instr_q <= d_instr;
         pc_q    <= d_pc;
      end
   end

   assign if_valid = valid_q;
   assign if_instr = instr_q;
   assign if_pc    = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, addresses imem and registers the result into IF/ID (1-cycle latency).
// Priority in RUN: halt > jmp (squash, one bubble) > stall (freeze PC and IF/ID) > advance.
module fetch_pc_unit
   import types_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter int                PC_INC   = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               jmp,
   input  logic [ADDR_W-1:0]  jmp_target,
   input  logic               halt,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic               halted
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] target_aligned;
   logic              ifid_load, ifid_clear;

   // With 2-byte instructions a jump can never land on an odd address.
   assign target_aligned = (PC_INC == 2) ? {jmp_target[ADDR_W-1:1], 1'b0} : jmp_target;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = halt ? HALTED : RUN;
         HALTED:  state_d = HALTED;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      pc_d       = pc_q;
      ifid_load  = 1'b0;
      ifid_clear = 1'b0;
      halted     = (state_q == HALTED);
      case (state_q)
         RUN: begin
            if (halt) begin
               ifid_clear = 1'b1;
            end else if (jmp) begin
               pc_d       = target_aligned;
               ifid_clear = 1'b1;
            end else if (!stall) begin
               pc_d      = pc_q + ADDR_W'(PC_INC);
               ifid_load = 1'b1;
            end
         end
         HALTED:  ifid_clear = 1'b1;
         default: ;
      endcase
   end

   assign imem_addr = pc_q;

   if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ifid_load),
      .clear    (ifid_clear),
      .d_valid  (1'b1),
      .d_instr  (imem_rdata),
      .d_pc     (pc_q),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .if_pc    (if_pc)
   );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboarded bench for fetch_pc_unit: directed plan followed by random stall/jmp/halt/reset traffic.
module tb_fetch_pc_unit;

   localparam int AW = 16;
   localparam int IW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic          jmp = 1'b0;
   logic          halt = 1'b0;
   logic [AW-1:0] jmp_target = '0;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          if_valid;
   logic [IW-1:0] if_instr;
   logic [AW-1:0] if_pc;
   logic          halted;

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h1234;
   endfunction

   assign imem_rdata = mem(imem_addr);

   fetch_pc_unit #(
      .ADDR_W   (AW),
      .INSTR_W  (IW),
      .PC_INC   (2),
      .RESET_PC (16'h0000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .halt       (halt),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .halted     (halted)
   );

   typedef struct packed {
      logic          v;
      logic [IW-1:0] instr;
      logic [AW-1:0] pc;
      logic          h;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   // Reference model: architectural PC, halted flag and expected IF/ID contents.
   logic [AW-1:0] m_pc = '0;
   bit            m_halted = 1'b0;
   exp_t          m_ifid = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Called 2 time units after a rising edge; drives one cycle and returns 2 units after the next edge.
   task automatic cycle(input bit s, input bit j, input logic [AW-1:0] t, input bit h);
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
      stall = s;
      jmp = j;
      jmp_target = t;
      halt = h;
      if (!m_halted) begin
         if (h) begin
            m_halted = 1'b1;
            m_ifid.v = 1'b0;
         end else if (j) begin
            m_pc = t & 16'hFFFE;
            m_ifid.v = 1'b0;
         end else if (!s) begin
            m_ifid.v = 1'b1;
            m_ifid.instr = mem(m_pc);
            m_ifid.pc = m_pc;
            m_pc = m_pc + 16'd2;
         end
      end
      m_ifid.h = m_halted;
      exp_q.push_back(m_ifid);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input bit j, input bit h, input bit s);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_imem_addr", 32'(imem_addr), 32'h0);
      check("rst_if_valid", 32'(if_valid), 32'h0);
      check("rst_if_instr", 32'(if_instr), 32'h0);
      check("rst_if_pc", 32'(if_pc), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      exp_q.delete();
      m_pc = '0;
      m_halted = 1'b0;
      m_ifid = '0;
      stall = s;
      jmp = j;
      halt = h;
      jmp_target = AW'($urandom);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      // The BOOT edge must have ignored whatever was on stall/jmp/halt.
      check("boot_if_valid", 32'(if_valid), 32'h0);
      check("boot_halted", 32'(halted), 32'h0);
      mon_en = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL scoreboard_empty: DUT if_valid=%b with no expected entry at %0t", if_valid, $time);
            end else begin
               e = exp_q.pop_front();
               check("if_valid", 32'(if_valid), 32'(e.v));
               check("halted", 32'(halted), 32'(e.h));
               if (e.v) begin
                  check("if_instr", 32'(if_instr), 32'(e.instr));
                  check("if_pc", 32'(if_pc), 32'(e.pc));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      #7;
      do_reset(1'b1, 1'b1, 1'b1);
      repeat (3) cycle(0, 0, 16'h0, 0);

      cycle(0, 1, 16'h0010, 0);
      cycle(0, 1, 16'h0041, 0);
      cycle(0, 0, 16'h0, 0);
      cycle(0, 0, 16'h0, 0);
      cycle(0, 0, 16'h0, 0);

      cycle(0, 1, 16'h0008, 0);
      cycle(0, 0, 16'h0, 0);
      repeat (3) cycle(1, 0, 16'h0, 0);
      repeat (2) cycle(0, 0, 16'h0, 0);

      cycle(1, 1, 16'h0100, 0);
      repeat (2) cycle(0, 0, 16'h0, 0);

      cycle(0, 1, 16'hFFFE, 0);
      repeat (3) cycle(0, 0, 16'h0, 0);

      cycle(0, 1, 16'h0020, 0);
      cycle(0, 0, 16'h0, 1);
      repeat (3) cycle(0, 1, 16'h0300, 0);
      repeat (2) cycle(1, 0, 16'h0, 1);
      do_reset(0, 0, 0);
      repeat (3) cycle(0, 0, 16'h0, 0);

      for (int i = 0; i < 800; i++) begin
         if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 249) == 0)
            do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  AW'($urandom), $urandom_range(0, 59) == 0);
      end

      do_reset(0, 0, 0);
      repeat (2) cycle(0, 0, 16'h0, 0);
      check("queue_drain", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
